// File: rtl/apb_slave_regfile.sv
// APB slave register file: NUM_REGS read/write words plus a read-only STATUS word,
// with a programmable number of wait states in every access phase.
module apb_slave_regfile #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_A000,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic [15:0] xfer_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    localparam logic [3:0]  WAIT_C    = 4'(WAIT_CYCLES);
    localparam logic [29:0] STATUS_W  = 30'd15;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] xfer_cnt_q;
    logic [31:0] regs_q [NUM_REGS];

    logic        access_s, complete_s, done_s, wr_en_s;
    logic        misalign_s, hit_reg_s, hit_status_s, err_s;
    logic [29:0] word_s;
    logic [31:0] rd_s;

    // State register and wait counter
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic for the phase tracker
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (psel_i && !penable_i) state_d = ST_SETUP;
                else                      state_d = ST_IDLE;
            end
            ST_SETUP: begin
                if (!psel_i) begin
                    state_d = ST_IDLE;
                end else if (penable_i) begin
                    if (WAIT_C == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = 4'd1;
                    end
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_ACCESS: begin
                // Leaving the access phase early is an abort; the count is discarded.
                if (!(psel_i && penable_i) || (cnt_q == WAIT_C)) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Completion strobe; an access seen in IDLE completes at once as an error
    always_comb begin
        access_s   = psel_i && penable_i;
        complete_s = 1'b0;
        case (state_q)
            ST_IDLE:   complete_s = access_s;
            ST_SETUP:  complete_s = access_s && (WAIT_C == 4'd0);
            ST_ACCESS: complete_s = access_s && (cnt_q == WAIT_C);
            default:   complete_s = 1'b0;
        endcase
    end

    // Address decode and error classification for the completing cycle
    always_comb begin
        misalign_s   = (paddr_i[1:0] != 2'b00);
        word_s       = paddr_i[31:2] - ADDR_BASE[31:2];
        hit_reg_s    = !misalign_s && (word_s < 30'(NUM_REGS));
        hit_status_s = !misalign_s && (word_s == STATUS_W);
        err_s        = (state_q == ST_IDLE) || !(hit_reg_s || hit_status_s)
                       || (hit_status_s && pwrite_i);
    end

    // Read mux over the register bank
    always_comb begin
        rd_s = 32'h0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (word_s == 30'(i)) rd_s = regs_q[i];
            else                  rd_s = rd_s;
        end
    end

    // Response outputs, forced low while reset is asserted
    always_comb begin
        done_s    = preset_n && complete_s;
        wr_en_s   = done_s && !err_s && pwrite_i && hit_reg_s;
        pready_o  = done_s;
        pslverr_o = done_s && err_s;
        if (done_s && !err_s && !pwrite_i) begin
            prdata_o = hit_status_s ? {16'h0, xfer_cnt_q} : rd_s;
        end else begin
            prdata_o = 32'h0;
        end
        xfer_cnt_o = xfer_cnt_q;
    end

    // Register bank and completed-transfer counter
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            xfer_cnt_q <= 16'd0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'h0;
        end else begin
            if (done_s && !err_s) xfer_cnt_q <= xfer_cnt_q + 16'd1;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en_s && (word_s == 30'(i))) regs_q[i] <= pwdata_i;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench: three slaves (1, 3 and 0 wait states) on one shared APB bus,
// checked against an address-arithmetic model of the register file.
module tb_apb_slave_regfile;

    localparam logic [31:0] BASE = 32'h0000_A000;
    localparam int          NREG = 8;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = 32'h0, pwdata = 32'h0;
    int          sel = 0;
    int          cyc = 0;

    logic [31:0] prd [3];
    logic        rdy [3];
    logic        serr [3];
    logic [15:0] xc [3];
    logic [31:0] prd_m;
    logic        rdy_m, serr_m;
    logic [15:0] xc_m;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    apb_slave_regfile #(.ADDR_BASE(BASE), .NUM_REGS(NREG), .WAIT_CYCLES(1)) u_w1 (
        .pclk(pclk), .preset_n(preset_n), .psel_i(psel && (sel == 0)), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prd[0]),
        .pready_o(rdy[0]), .pslverr_o(serr[0]), .xfer_cnt_o(xc[0]));
    apb_slave_regfile #(.ADDR_BASE(BASE), .NUM_REGS(NREG), .WAIT_CYCLES(3)) u_w3 (
        .pclk(pclk), .preset_n(preset_n), .psel_i(psel && (sel == 1)), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prd[1]),
        .pready_o(rdy[1]), .pslverr_o(serr[1]), .xfer_cnt_o(xc[1]));
    apb_slave_regfile #(.ADDR_BASE(BASE), .NUM_REGS(NREG), .WAIT_CYCLES(0)) u_w0 (
        .pclk(pclk), .preset_n(preset_n), .psel_i(psel && (sel == 2)), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prd[2]),
        .pready_o(rdy[2]), .pslverr_o(serr[2]), .xfer_cnt_o(xc[2]));

    always_comb begin
        prd_m  = prd[sel];
        rdy_m  = rdy[sel];
        serr_m = serr[sel];
        xc_m   = xc[sel];
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [31:0] mregs [3][NREG];
    logic [15:0] mcnt [3];
    int          tests = 0, fails = 0;

    function automatic int wait_of(int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic void clear_model();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 16'd0;
            for (int i = 0; i < NREG; i++) mregs[k][i] = 32'h0;
        end
    endfunction

    // Expected outcome of a transfer that runs to completion; updates the model.
    function automatic exp_t predict(int k, logic wr, logic [31:0] addr, logic [31:0] data);
        exp_t        e;
        logic [31:0] off;
        int          w;
        logic        err;
        off = addr - BASE;
        w   = int'(off >> 2);
        err = (addr[1:0] != 2'b00) || ((off >> 2) >= 32'(NREG) && (off >> 2) != 32'd15)
              || ((off >> 2) == 32'd15 && wr);
        e.err  = err;
        e.cnt  = mcnt[k];
        e.data = 32'h0;
        e.cyc  = 0;
        if (!err) begin
            if (wr)           mregs[k][w] = data;
            else if (w == 15) e.data = {16'h0, mcnt[k]};
            else              e.data = mregs[k][w];
            mcnt[k] = mcnt[k] + 16'd1;
        end
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // All bus tasks start and end aligned to a rising edge.
    task automatic idle(int n);
        #1 psel = 1'b0; penable = 1'b0;
        repeat (n) @(posedge pclk);
    endtask

    task automatic xfer(int k, logic wr, logic [31:0] addr, logic [31:0] data, int abort_after);
        exp_t e;
        int   n;
        #1 psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        if (abort_after < 0) begin
            e     = predict(k, wr, addr, data);
            e.cyc = cyc + 1 + wait_of(k);
            exp_q.push_back(e);
        end
        @(posedge pclk);
        #1 penable = 1'b1;
        if (abort_after >= 0) begin
            repeat (abort_after) @(posedge pclk);
            #1 psel = 1'b0; penable = 1'b0;
            @(posedge pclk);
            return;
        end
        n = 0;
        while (n < 40) begin
            @(negedge pclk);
            if (rdy_m === 1'b1) break;
            n++;
        end
        if (n >= 40) begin
            tests++;
            fails++;
            $display("FAIL timeout: no pready for addr %h, expected within %0d cycles", addr, wait_of(k) + 1);
        end
        @(posedge pclk);
    endtask

    // Access phase driven with no preceding setup: completes at once with an error.
    task automatic idle_err(int k, logic wr, logic [31:0] addr);
        exp_t e;
        #1 psel = 1'b1; penable = 1'b1; pwrite = wr; paddr = addr; pwdata = 32'h5A5A_5A5A;
        e.data = 32'h0;
        e.err  = 1'b1;
        e.cnt  = mcnt[k];
        e.cyc  = cyc;
        exp_q.push_back(e);
        @(posedge pclk);
        idle(1);
    endtask

    task automatic do_reset();
        #1 preset_n = 1'b0; psel = 1'b0; penable = 1'b0;
        clear_model();
        repeat (2) @(posedge pclk);
        #1 preset_n = 1'b1;
        @(posedge pclk);
    endtask

    // Monitor: every completion of the selected slave is matched against the scoreboard.
    always @(negedge pclk) begin
        if (preset_n === 1'b1 && rdy_m === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pready: slave %0d addr %h got pready 1 expected 0", sel, paddr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("prdata", prd_m, mon_e.data);
                chk("pslverr", {31'b0, serr_m}, {31'b0, mon_e.err});
                chk("xfer_cnt", {16'b0, xc_m}, {16'b0, mon_e.cnt});
                chk("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        int          r;
        logic        wr;
        logic [31:0] addr;

        clear_model();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            chk("reset_pready", {31'b0, rdy[k]}, 32'h0);
            chk("reset_prdata", prd[k], 32'h0);
            chk("reset_xfer_cnt", {16'b0, xc[k]}, 32'h0);
        end

        // One wait state: read, write/read-back, STATUS, error cases
        sel = 0;
        xfer(0, 1'b0, BASE, 32'h0, -1);
        idle(1);
        chk("cnt_after_first_read", {16'b0, xc_m}, 32'd1);
        xfer(0, 1'b1, BASE, 32'h0000_0001, -1);
        xfer(0, 1'b0, BASE, 32'h0, -1);
        xfer(0, 1'b0, BASE + 32'h3C, 32'h0, -1);
        xfer(0, 1'b1, BASE + 32'h2, 32'hFFFF_FFFF, -1);
        xfer(0, 1'b1, BASE + 32'h20, 32'hFFFF_FFFF, -1);
        xfer(0, 1'b1, BASE + 32'h3C, 32'hFFFF_FFFF, -1);
        xfer(0, 1'b0, BASE - 32'h4, 32'h0, -1);
        xfer(0, 1'b0, BASE + 32'h40, 32'h0, -1);
        xfer(0, 1'b1, BASE + 32'h1C, 32'hCAFE_F00D, -1);
        xfer(0, 1'b0, BASE + 32'h1C, 32'h0, -1);
        xfer(0, 1'b0, BASE, 32'h0, -1);
        idle(1);
        idle_err(0, 1'b0, BASE);
        idle(1);
        chk("cnt_after_errors", {16'b0, xc_m}, {16'b0, mcnt[0]});

        // Three wait states: abort after one access cycle, then a full transfer
        sel = 1;
        xfer(1, 1'b1, BASE + 32'h8, 32'h1234_5678, 1);
        xfer(1, 1'b0, BASE + 32'h8, 32'h0, -1);
        xfer(1, 1'b1, BASE + 32'h8, 32'h1234_5678, -1);
        xfer(1, 1'b0, BASE + 32'h8, 32'h0, -1);
        idle(1);

        // Reset asserted mid-wait during a write of DEADBEEF
        #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h4; pwdata = 32'hDEAD_BEEF;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(posedge pclk);
        #2 preset_n = 1'b0;
        #1;
        chk("async_rst_pready", {31'b0, rdy_m}, 32'h0);
        chk("async_rst_pslverr", {31'b0, serr_m}, 32'h0);
        chk("async_rst_prdata", prd_m, 32'h0);
        chk("async_rst_xfer_cnt", {16'b0, xc_m}, 32'h0);
        clear_model();
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk);
        #1 preset_n = 1'b1;
        @(posedge pclk);
        xfer(1, 1'b0, BASE + 32'h4, 32'h0, -1);
        xfer(1, 1'b0, BASE + 32'h8, 32'h0, -1);
        idle(1);

        // No wait states: 20 back-to-back read / write-increment transfers
        do_reset();
        sel = 2;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) xfer(2, 1'b0, BASE, 32'h0, -1);
            else            xfer(2, 1'b1, BASE, mregs[2][0] + 32'h1, -1);
        end
        idle(1);
        chk("b2b_xfer_cnt", {16'b0, xc_m}, 32'd20);
        xfer(2, 1'b0, BASE, 32'h0, -1);
        idle(1);

        // Randomized traffic on every slave
        for (int k = 0; k < 3; k++) begin
            sel = k;
            for (int t = 0; t < 40; t++) begin
                r  = $urandom_range(0, 9);
                wr = 1'($urandom_range(0, 1));
                case (r)
                    5:       addr = BASE + 32'h3C;
                    6:       addr = BASE + 32'(4 * $urandom_range(NREG, 14));
                    7:       addr = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
                    8:       addr = BASE - 32'(4 * $urandom_range(1, 4));
                    default: addr = BASE + 32'(4 * $urandom_range(0, NREG - 1));
                endcase
                if (r == 9) idle_err(k, wr, addr);
                else        xfer(k, wr, addr, $urandom, -1);
                if ($urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 2));
            end
            idle(2);
        end

        idle(3);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_completions: got %0d outstanding expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
